// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial-to-parallel frame controller:
// FSM state encoding and the default frame width.
package shiftreg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/shiftreg_en.sv
// WIDTH-bit MSB-first shift register with shift enable and synchronous clear.
// Exposes its next value so the controller can capture a frame on the same edge.
module shiftreg_en #(
  parameter int WIDTH = shiftreg_pkg::DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (i_clr) begin
      q_d = '0;
    end else if (i_en) begin
      q_d = {q_q[WIDTH-2:0], i_bit};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q_next = q_d;

endmodule

// File: rtl/shiftreg_ctrl.sv
// Serial frame assembler: collects WIDTH bits MSB first, presents the word with a
// valid/ready handshake and flags bits that arrive while a word is still held.
module shiftreg_ctrl
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_ready,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic               busy_q;
  logic               overrun_q;
  logic               overrun_d;

  logic               sr_clr;
  logic               sr_en;
  logic [WIDTH-1:0]   sr_next;
  logic               handshake;
  logic               overrun_set;

  assign handshake = valid_q & i_ready;

  // Shift-register control mirrors the FSM decisions below for the same cycle.
  always_comb begin
    sr_clr      = 1'b0;
    sr_en       = 1'b0;
    overrun_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        sr_clr = i_start;
      end
      SHIFT: begin
        if (i_start) begin
          sr_clr = 1'b1;
        end else begin
          sr_en = i_bit_valid;
        end
      end
      HOLD: begin
        overrun_set = i_bit_valid;
        sr_clr      = handshake & i_start;
      end
      default: begin
        sr_clr = 1'b1;
      end
    endcase
    overrun_d = overrun_set | (overrun_q & ~i_clr);
  end

  shiftreg_en #(
    .WIDTH(WIDTH)
  ) u_sr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (sr_clr),
    .i_en     (sr_en),
    .i_bit    (i_bit),
    .o_q_next (sr_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (i_start) begin
            cnt_q <= '0;
          end else if (i_bit_valid) begin
            if (cnt_q == LAST_CNT) begin
              // The edge capturing the last bit loads the word straight from the shifter.
              data_q  <= sr_next;
              valid_q <= 1'b1;
              state_q <= HOLD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            if (i_start) begin
              state_q <= SHIFT;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule
